// File: rtl/bcd_converter_ext_if.sv
// Handshake and result bundle between a game-state counter and
// the iterative binary-to-BCD converter.
interface bcd_converter_ext_if #(
    parameter int INPUT_WIDTH    = 8,
    parameter int DECIMAL_DIGITS = 3
);
    logic [INPUT_WIDTH-1:0]      i_Binary;
    logic                        i_Signed;
    logic                        i_Start;
    logic                        o_Busy;
    logic [DECIMAL_DIGITS*4-1:0] o_BCD;
    logic                        o_Neg;
    logic [DECIMAL_DIGITS-1:0]   o_Blank;
    logic                        o_Overflow;
    logic                        o_DV;

    modport master (
        output i_Binary, i_Signed, i_Start,
        input  o_Busy, o_BCD, o_Neg, o_Blank, o_Overflow, o_DV
    );

    modport slave (
        input  i_Binary, i_Signed, i_Start,
        output o_Busy, o_BCD, o_Neg, o_Blank, o_Overflow, o_DV
    );
endinterface

// File: rtl/bcd_converter_ext.sv
// Iterative double-dabble converter: one input bit per cycle, all
// digits adjusted in parallel, signed input, saturation and blanking.
module bcd_converter_ext #(
    parameter int INPUT_WIDTH    = 8,
    parameter int DECIMAL_DIGITS = 3
) (
    input  logic                i_Clock,
    input  logic                i_Reset,
    bcd_converter_ext_if.slave  bus
);
    localparam int BW = DECIMAL_DIGITS * 4;
    localparam int CW = $clog2(INPUT_WIDTH + 1);
    localparam logic [DECIMAL_DIGITS-1:0] BLANK_RST = ~DECIMAL_DIGITS'(1);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [INPUT_WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]           acc_q, acc_d;
    logic                    sticky_q, sticky_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    neg_q, neg_d;
    logic [BW-1:0]           bcd_q, bcd_d;
    logic                    oneg_q, oneg_d;
    logic                    ovf_q, ovf_d;
    logic [DECIMAL_DIGITS-1:0] blank_q, blank_d;
    logic                    busy_q, busy_d;
    logic                    dv_q, dv_d;

    logic [BW-1:0]           adj;
    logic [BW-1:0]           fin;
    logic [DECIMAL_DIGITS-1:0] fin_blank;
    logic                    zero_run;
    logic                    in_neg;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            bcd_q    <= '0;
            oneg_q   <= 1'b0;
            ovf_q    <= 1'b0;
            blank_q  <= BLANK_RST;
            busy_q   <= 1'b0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            bcd_q    <= bcd_d;
            oneg_q   <= oneg_d;
            ovf_q    <= ovf_d;
            blank_q  <= blank_d;
            busy_q   <= busy_d;
            dv_q     <= dv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        bcd_d    = bcd_q;
        oneg_d   = oneg_q;
        ovf_d    = ovf_q;
        blank_d  = blank_q;
        busy_d   = busy_q;
        dv_d     = 1'b0;
        in_neg   = bus.i_Signed & bus.i_Binary[INPUT_WIDTH-1];

        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            adj[i*4 +: 4] = (acc_q[i*4 +: 4] > 4'd4) ?
                            acc_q[i*4 +: 4] + 4'd3 : acc_q[i*4 +: 4];
        end

        // Saturated result and its leading-zero mask, scanned from the top
        fin       = sticky_q ? {DECIMAL_DIGITS{4'h9}} : acc_q;
        fin_blank = '0;
        zero_run  = 1'b1;
        for (int i = DECIMAL_DIGITS - 1; i > 0; i--) begin
            zero_run     = zero_run & (fin[i*4 +: 4] == 4'd0);
            fin_blank[i] = zero_run;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.i_Start) begin
                    neg_d    = in_neg;
                    shift_d  = in_neg ?
                               ~bus.i_Binary + INPUT_WIDTH'(1) :
                               bus.i_Binary;
                    acc_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = CONVERT;
                end
            end
            CONVERT: begin
                acc_d    = {adj[BW-2:0], shift_q[INPUT_WIDTH-1]};
                sticky_d = sticky_q | adj[BW-1];
                shift_d  = shift_q << 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(INPUT_WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = fin;
                oneg_d  = neg_q & (sticky_q | (acc_q != '0));
                ovf_d   = sticky_q;
                blank_d = fin_blank;
                dv_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_Busy     = busy_q;
    assign bus.o_BCD      = bcd_q;
    assign bus.o_Neg      = oneg_q;
    assign bus.o_Blank    = blank_q;
    assign bus.o_Overflow = ovf_q;
    assign bus.o_DV       = dv_q;
endmodule

// File: doc/bcd_converter_ext.md
Name: bcd_converter_ext

Overview:
Parametrised iterative double-dabble binary-to-BCD converter for score and timer displays. Successor to the 2-digit display converter, with these additions:
- synchronous reset;
- one-cycle-per-bit conversion, with all digits adjusted in parallel;
- optional two's-complement input;
- overflow detection with saturation;
- leading-zero blanking mask.

Sits between game-state counters and the seven-segment or VGA digit renderers, on the single system clock.

Parameters:
INPUT_WIDTH, 8, width of binary input (>=2).
DECIMAL_DIGITS, 3, number of BCD output digits (>=1).

Ports:
i_Clock  in  1  system clock; all logic on rising edge.
i_Reset  in  1  synchronous, active-high reset.
i_Binary  in  INPUT_WIDTH  value to convert; sampled only when a start is accepted.
i_Signed  in  1  1 = treat i_Binary as two's complement; sampled with i_Binary.
i_Start  in  1  conversion request; accepted only when o_Busy=0.
o_Busy  out  1  conversion in progress.
o_BCD  out  DECIMAL_DIGITS*4  result, digit 0 in bits [3:0]; held until the next o_DV.
o_Neg  out  1  result is negative; held with o_BCD.
o_Blank  out  DECIMAL_DIGITS  bit i=1 means digit i is a leading zero; bit 0 is always 0.
o_Overflow  out  1  magnitude >= 10^DECIMAL_DIGITS; held with o_BCD.
o_DV  out  1  single-cycle pulse when new outputs are valid.

Behaviour:
- Clock and reset: one clock, i_Clock. i_Reset is synchronous and active-high. Reset dominates i_Start.
- Reset values: FSM=IDLE; o_Busy=0, o_DV=0, o_BCD=0, o_Neg=0, o_Overflow=0, o_Blank={DECIMAL_DIGITS-1{1'b1}},1'b0; internal shift register, BCD accumulator, sticky overflow and bit counter all 0.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - o_Busy=0.
  - If i_Start=1 at edge k:
    - neg = i_Signed & i_Binary[MSB];
    - magnitude = neg ? (~i_Binary+1) : i_Binary, kept INPUT_WIDTH bits unsigned, so the most negative value yields 2^(INPUT_WIDTH-1) correctly;
    - clear accumulator and sticky overflow; counter=0; go to CONVERT.
- CONVERT (edges k+1 .. k+INPUT_WIDTH, exactly INPUT_WIDTH cycles):
  - Each cycle, add 3 to every accumulator digit >4, in parallel.
  - Then shift the adjusted accumulator left by 1, inserting the magnitude MSB at bit 0; shift the magnitude left by 1.
  - The bit shifted out of the accumulator top is ORed into sticky overflow.
  - Counter increments; after the INPUT_WIDTH-th shift, go to DONE.
  - o_Busy=1 throughout.
- DONE (edge k+INPUT_WIDTH+1):
  - o_BCD = overflow ? all digits 4'h9 : accumulator.
  - o_Neg = neg, except 0 when the magnitude is 0.
  - o_Overflow = sticky overflow.
  - o_Blank[i] (i>0) = 1 iff digit i and all higher digits of o_BCD are 0; all 0 when overflow.
  - o_DV=1 for this one cycle; return to IDLE.
- Latency and throughput: outputs are visible INPUT_WIDTH+2 cycles after the cycle in which start is sampled. o_Busy is 1 from edge k through the cycle before o_DV, and 0 in the o_DV cycle. Back-to-back: a start asserted in the o_DV cycle is accepted, giving throughput of one result per INPUT_WIDTH+2 cycles.
- i_Start while o_Busy=1: ignored, not queued. i_Binary and i_Signed changes during CONVERT have no effect.
- Reset mid-conversion: abort, all outputs to reset values, no o_DV pulse.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. W=8, D=3, i_Binary=8'd255, i_Signed=0, start -> after 10 cycles o_DV=1, o_BCD=12'h255, o_Blank=3'b000, o_Neg=0, o_Overflow=0.
2. W=8, D=3, i_Binary=8'h80, i_Signed=1 -> o_BCD=12'h128, o_Neg=1. Then i_Binary=8'hFF, i_Signed=1 -> o_BCD=12'h001, o_Neg=1, o_Blank=3'b110.
3. W=8, D=3, i_Binary=0 -> o_BCD=12'h000, o_Blank=3'b110, o_Neg=0. Then i_Binary=8'd7 -> o_BCD=12'h007, o_Blank=3'b110. Then i_Binary=8'd40 -> o_BCD=12'h040, o_Blank=3'b100.
4. W=8, D=2, i_Binary=8'd100 -> o_Overflow=1, o_BCD=8'h99, o_Blank=2'b00. Then i_Binary=8'd99 -> o_Overflow=0, o_BCD=8'h99.
5. Handshake: start with 8'd12, pulse start with 8'd34 at cycle 3 -> one o_DV, o_BCD=12'h012. Start with 8'd34 held high in the o_DV cycle -> next o_DV exactly 10 cycles later with 12'h034.
6. Reset mid-conversion: i_Reset=1 at cycle 4 of a conversion -> next cycle o_Busy=0, o_BCD=0, o_Overflow=0, and no o_DV. A start afterwards converts normally.
